// File: rtl/stack_pkg.sv
// Shared defaults and width derivations for the stack unit.
package stack_pkg;

    localparam int unsigned STACK_WIDTH_DEF = 8;
    localparam int unsigned STACK_DEPTH_DEF = 8;

    // Count needs one extra bit so that DEPTH itself is representable.
    function automatic int unsigned stack_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned STACK_CNT_W_DEF = stack_cnt_w(STACK_DEPTH_DEF);

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module stack_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered top-of-stack capture and sticky error flags.
// Build option: define STACK_GUARD_EN to ignore push-when-full and
// pop-when-empty (setting ovf/unf); otherwise the count wraps and the flags
// stay at 0.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH_DEF,
    parameter int unsigned DEPTH = STACK_DEPTH_DEF,
    localparam int unsigned CW   = stack_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    cnt_nxt;
    logic             ovf_set;
    logic             unf_set;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    // Top entry; index wraps when empty, which is masked at capture time.
    assign rd_idx = AW'(count - CW'(1));

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we      (we),
        .wr_idx  (wr_idx),
        .wr_data (d_in),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Decode push/pop into a write request, next count and flag events.
    always_comb begin
        we      = 1'b0;
        wr_idx  = AW'(count);
        cnt_nxt = count;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push && pop && !empty) begin
            we     = 1'b1;
            wr_idx = rd_idx;
        end else if (push) begin
`ifdef STACK_GUARD_EN
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                we      = 1'b1;
                cnt_nxt = count + CW'(1);
            end
`else
            // A full stack is treated as count 0: write index 0, count 1.
            we      = 1'b1;
            cnt_nxt = full ? CW'(1) : count + CW'(1);
`endif
        end else if (pop) begin
`ifdef STACK_GUARD_EN
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                cnt_nxt = count - CW'(1);
            end
`else
            cnt_nxt = empty ? CW'(DEPTH - 1) : count - CW'(1);
`endif
        end
    end

    // Count, captured top-of-stack and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            d_out <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= cnt_nxt;
            if (tos) begin
                d_out <= empty ? '0 : rd_data;
            end
            ovf <= ovf | ovf_set;
            unf <= unf | unf_set;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit (default WIDTH=8, DEPTH=8).
module tb_stack_unit;

    localparam int F_DOUT  = 0;
    localparam int F_COUNT = 1;
    localparam int F_EMPTY = 2;
    localparam int F_FULL  = 3;
    localparam int F_OVF   = 4;
    localparam int F_UNF   = 5;

    typedef struct {
        string nm;
        int    fld;
        int    val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       tos;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;

    exp_t sb[$];
    int   total;
    int   bad;
    event chk_now;

    stack_unit dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .tos   (tos),
        .d_in  (d_in),
        .d_out (d_out),
        .count (count),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fname(input int f);
        case (f)
            F_DOUT:  return "d_out";
            F_COUNT: return "count";
            F_EMPTY: return "empty";
            F_FULL:  return "full";
            F_OVF:   return "ovf";
            default: return "unf";
        endcase
    endfunction

    // Monitor: drain expectations after each edge, or on demand.
    always begin
        @(negedge clk or chk_now);
        while (sb.size() > 0) begin
            exp_t e;
            int   act;
            e = sb.pop_front();
            case (e.fld)
                F_DOUT:  act = 32'(d_out);
                F_COUNT: act = 32'(count);
                F_EMPTY: act = 32'(empty);
                F_FULL:  act = 32'(full);
                F_OVF:   act = 32'(ovf);
                default: act = 32'(unf);
            endcase
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s %s got=%0h want=%0h", e.nm, fname(e.fld), act, e.val);
            end
        end
    end

    task automatic expect_v(input string nm, input int fld, input int val);
        exp_t e;
        e.nm  = nm;
        e.fld = fld;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drive(input logic p, input logic po, input logic t, input logic [7:0] d);
        @(negedge clk);
        #1;
        push = p;
        pop  = po;
        tos  = t;
        d_in = d;
    endtask

    task automatic sync_reset();
        @(negedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        #1;
        rst  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        tos   = 1'b0;
        d_in  = 8'h00;

        // Reset state.
        #2;
        expect_v("rst", F_COUNT, 0);
        expect_v("rst", F_EMPTY, 1);
        expect_v("rst", F_FULL, 0);
        expect_v("rst", F_DOUT, 0);
        expect_v("rst", F_OVF, 0);
        expect_v("rst", F_UNF, 0);
        ->chk_now;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Three pushes then capture top.
        drive(1, 0, 0, 8'h11);
        drive(1, 0, 0, 8'h22);
        drive(1, 0, 0, 8'h33);
        expect_v("push3", F_COUNT, 3);
        drive(0, 0, 1, 8'h00);
        expect_v("tos3", F_DOUT, 'h33);
        expect_v("tos3", F_COUNT, 3);

        // Pop+tos captures the pre-pop top.
        drive(0, 1, 1, 8'h00);
        expect_v("poptos", F_DOUT, 'h33);
        expect_v("poptos", F_COUNT, 2);
        drive(0, 0, 1, 8'h00);
        expect_v("tos2", F_DOUT, 'h22);

        // Replace top.
        drive(1, 1, 0, 8'hAB);
        expect_v("replace", F_COUNT, 2);
        drive(0, 0, 1, 8'h00);
        expect_v("replace_tos", F_DOUT, 'hAB);
        expect_v("replace_tos", F_COUNT, 2);

        // Fill to full, then push once more.
        sync_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 0, 8'(i));
        end
        expect_v("fill", F_COUNT, 8);
        expect_v("fill", F_FULL, 1);
        expect_v("fill", F_EMPTY, 0);
        drive(1, 0, 0, 8'h09);
`ifdef STACK_GUARD_EN
        expect_v("ovpush", F_COUNT, 8);
        expect_v("ovpush", F_OVF, 1);
        drive(0, 0, 1, 8'h00);
        expect_v("ovtos", F_DOUT, 'h08);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'h00);
        end
        drive(0, 0, 1, 8'h00);
        expect_v("cnt5", F_COUNT, 5);
        expect_v("cnt5", F_DOUT, 'h05);
        expect_v("cnt5", F_OVF, 1);
`else
        expect_v("ovpush", F_COUNT, 1);
        expect_v("ovpush", F_OVF, 0);
        drive(0, 0, 1, 8'h00);
        expect_v("ovtos", F_DOUT, 'h09);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 8'(8'h0A + i));
        end
        drive(0, 0, 1, 8'h00);
        expect_v("cnt5", F_COUNT, 5);
        expect_v("cnt5", F_DOUT, 'h0D);
        expect_v("cnt5", F_OVF, 0);
`endif

        // Asynchronous reset mid-cycle.
        drive(0, 0, 0, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_v("arst", F_COUNT, 0);
        expect_v("arst", F_OVF, 0);
        expect_v("arst", F_DOUT, 0);
        expect_v("arst", F_EMPTY, 1);
        ->chk_now;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Pop while empty.
        drive(0, 1, 0, 8'h00);
`ifdef STACK_GUARD_EN
        expect_v("unfpop", F_UNF, 1);
        expect_v("unfpop", F_COUNT, 0);
        expect_v("unfpop", F_EMPTY, 1);
        drive(0, 0, 1, 8'h00);
        expect_v("unftos", F_DOUT, 0);
        drive(1, 0, 0, 8'h44);
        expect_v("unfsticky", F_UNF, 1);
        expect_v("unfsticky", F_COUNT, 1);
`else
        expect_v("unfpop", F_UNF, 0);
        expect_v("unfpop", F_COUNT, 7);
`endif

        // tos while empty yields zero.
        sync_reset();
        drive(1, 0, 1, 8'h5A);
        expect_v("etos_a", F_DOUT, 0);
        drive(0, 0, 1, 8'h00);
        expect_v("etos_b", F_DOUT, 'h5A);
        drive(0, 1, 0, 8'h00);
        expect_v("etos_c", F_EMPTY, 1);
        drive(0, 0, 1, 8'h00);
        expect_v("etos_d", F_DOUT, 0);

        // Push+pop while empty acts as push.
        sync_reset();
        drive(1, 1, 0, 8'hC3);
        expect_v("pp_empty", F_COUNT, 1);
        expect_v("pp_empty", F_UNF, 0);
        drive(0, 0, 1, 8'h00);
        expect_v("pp_tos", F_DOUT, 'hC3);

        drive(0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
